sync_fifo_param: RTL and testbench

- Parametrised single-clock FIFO; next generation of the 32x16 queue.
- Adds configurable width and depth, a true full condition (all DEPTH entries usable) and an occupancy count.
- Adds programmable almost-full/almost-empty flags, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between any producer/consumer pair in the same clock domain.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_ram.sv | 27 ++
 rtl/sync_fifo_param.sv | 144 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the parametrised synchronous FIFO.
// Pointer and count widths are derived from DEPTH alone.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so that COUNT can represent DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit params_ok(input int width, input int depth,
                                     input int ae_level, input int af_level,
                                     input int fwft);
        return (width >= 1) && (depth >= 2) && is_pow2(depth) &&
               (ae_level >= 0) && (ae_level < af_level) &&
               (af_level <= depth) && ((fwft == 0) || (fwft == 1));
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
// Deliberately unreset so synthesis can map it onto distributed or block RAM.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ptr_w(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [ptr_w(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]        rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses and selectable standard or first-word-fall-through read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    WR,
    input  logic [WIDTH-1:0]        DIN,
    input  logic                    RD,
    output logic [WIDTH-1:0]        DOUT,
    output logic                    DOUT_VALID,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic                    ALMOST_FULL,
    output logic                    ALMOST_EMPTY,
    output logic [cnt_w(DEPTH)-1:0] COUNT,
    output logic                    OVERFLOW,
    output logic                    UNDERFLOW
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t AF_C    = cnt_t'(AF_LEVEL);
    localparam cnt_t AE_C    = cnt_t'(AE_LEVEL);

    if (!params_ok(WIDTH, DEPTH, AE_LEVEL, AF_LEVEL, FWFT)) begin : g_param_check
        $fatal(1, "sync_fifo_param: illegal parameters WIDTH=%0d DEPTH=%0d AE=%0d AF=%0d FWFT=%0d",
               WIDTH, DEPTH, AE_LEVEL, AF_LEVEL, FWFT);
    end

    ptr_t             wr_ptr_q;
    ptr_t             rd_ptr_q;
    cnt_t             count_q;
    cnt_t             count_nxt;
    logic             full_q;
    logic             empty_q;
    logic             af_q;
    logic             ae_q;
    logic             ovf_q;
    logic             unf_q;
    logic             rd_acc;
    logic             wr_acc;
    logic [WIDTH-1:0] ram_rdata;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = RD && !empty_q;
    assign wr_acc = WR && (!full_q || rd_acc);

    always_comb begin
        count_nxt = count_q;
        if (wr_acc && !rd_acc) begin
            count_nxt = count_q + cnt_t'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count_q - cnt_t'(1);
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (CLK),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (DIN),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // Pointers wrap through their natural width; flags track post-edge occupancy.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
            count_q <= count_nxt;
            full_q  <= (count_nxt == DEPTH_C);
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= AF_C);
            ae_q    <= (count_nxt <= AE_C);
            ovf_q   <= WR && full_q && !rd_acc;
            unf_q   <= RD && empty_q;
        end
    end

    if (MODE == FIFO_FWFT) begin : g_fwft
        assign DOUT       = ram_rdata;
        assign DOUT_VALID = !empty_q;
    end else begin : g_std
        logic [WIDTH-1:0] dout_p1;
        logic             dout_vld_p1;

        // Registered read stage: one cycle from accepted RD to DOUT.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                dout_p1     <= '0;
                dout_vld_p1 <= 1'b0;
            end else begin
                dout_vld_p1 <= rd_acc;
                if (rd_acc) begin
                    dout_p1 <= ram_rdata;
                end
            end
        end

        assign DOUT       = dout_p1;
        assign DOUT_VALID = dout_vld_p1;
    end

    assign COUNT        = count_q;
    assign FULL         = full_q;
    assign EMPTY        = empty_q;
    assign ALMOST_FULL  = af_q;
    assign ALMOST_EMPTY = ae_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param: standard-mode instance at
// DEPTH=32 plus a first-word-fall-through instance sharing clock and reset.
module tb_sync_fifo_param;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WR;
    logic [15:0] DIN;
    logic        RD;
    logic [15:0] DOUT;
    logic        DOUT_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;
    logic [5:0]  COUNT;

    logic        f_wr;
    logic [15:0] f_din;
    logic        f_rd;
    logic [15:0] f_dout;
    logic        f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [5:0]  f_count;

    int passed = 0;
    int total  = 0;

    always #5 CLK = ~CLK;

    sync_fifo_param #(.WIDTH(16), .DEPTH(32), .AF_LEVEL(28), .AE_LEVEL(4), .FWFT(0)) dut (
        .CLK(CLK), .RST(RST), .WR(WR), .DIN(DIN), .RD(RD), .DOUT(DOUT),
        .DOUT_VALID(DOUT_VALID), .FULL(FULL), .EMPTY(EMPTY), .ALMOST_FULL(ALMOST_FULL),
        .ALMOST_EMPTY(ALMOST_EMPTY), .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    sync_fifo_param #(.WIDTH(16), .DEPTH(32), .AF_LEVEL(28), .AE_LEVEL(4), .FWFT(1)) dut_fwft (
        .CLK(CLK), .RST(RST), .WR(f_wr), .DIN(f_din), .RD(f_rd), .DOUT(f_dout),
        .DOUT_VALID(f_valid), .FULL(f_full), .EMPTY(f_empty), .ALMOST_FULL(f_af),
        .ALMOST_EMPTY(f_ae), .COUNT(f_count), .OVERFLOW(f_ovf), .UNDERFLOW(f_unf)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        // flags packed as {EMPTY,FULL,AE,AF,DOUT_VALID,OVERFLOW,UNDERFLOW}
        total++;
        if ({EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, DOUT_VALID, OVERFLOW, UNDERFLOW} !== 7'b1010000)
            $display("FAIL reset_flags got=%b exp=1010000",
                     {EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, DOUT_VALID, OVERFLOW, UNDERFLOW});
        else passed++;
        total++;
        if (COUNT !== 6'd0 || DOUT !== 16'h0000)
            $display("FAIL reset_count_dout got count=%0d dout=%h exp 0/0000", COUNT, DOUT);
        else passed++;
        total++;
        if (f_empty !== 1'b1 || f_valid !== 1'b0 || f_count !== 6'd0)
            $display("FAIL reset_fwft got empty=%b valid=%b count=%0d exp 1/0/0", f_empty, f_valid, f_count);
        else passed++;
    endtask

    task automatic fill_plain(input logic [15:0] base);
        for (int k = 0; k < 32; k++) begin
            WR = 1'b1; DIN = base + 16'(k);
            tick();
        end
        WR = 1'b0;
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 32; k++) begin
            WR = 1'b1; DIN = 16'(k);
            tick();
            total++;
            if (COUNT !== 6'(k) || FULL !== (k == 32) || ALMOST_FULL !== (k >= 28) ||
                ALMOST_EMPTY !== (k <= 4) || EMPTY !== 1'b0)
                $display("FAIL fill_%0d got count=%0d full=%b af=%b ae=%b empty=%b", k,
                         COUNT, FULL, ALMOST_FULL, ALMOST_EMPTY, EMPTY);
            else passed++;
        end
        DIN = 16'hDEAD;
        tick();
        total++;
        if (OVERFLOW !== 1'b1 || COUNT !== 6'd32 || FULL !== 1'b1)
            $display("FAIL overflow got ovf=%b count=%0d full=%b exp 1/32/1", OVERFLOW, COUNT, FULL);
        else passed++;
        WR = 1'b0;
        tick();
        total++;
        if (OVERFLOW !== 1'b0 || COUNT !== 6'd32)
            $display("FAIL overflow_pulse got ovf=%b count=%0d exp 0/32", OVERFLOW, COUNT);
        else passed++;
    endtask

    task automatic test_drain();
        for (int k = 1; k <= 32; k++) begin
            RD = 1'b1;
            tick();
            total++;
            if (DOUT !== 16'(k) || DOUT_VALID !== 1'b1 || COUNT !== 6'(32 - k))
                $display("FAIL drain_%0d got dout=%h valid=%b count=%0d exp %h/1/%0d", k,
                         DOUT, DOUT_VALID, COUNT, 16'(k), 32 - k);
            else passed++;
        end
        total++;
        if (EMPTY !== 1'b1 || ALMOST_EMPTY !== 1'b1)
            $display("FAIL drain_empty got empty=%b ae=%b exp 1/1", EMPTY, ALMOST_EMPTY);
        else passed++;
        tick();
        total++;
        if (UNDERFLOW !== 1'b1 || DOUT !== 16'h0020 || DOUT_VALID !== 1'b0 || COUNT !== 6'd0)
            $display("FAIL underflow got unf=%b dout=%h valid=%b count=%0d exp 1/0020/0/0",
                     UNDERFLOW, DOUT, DOUT_VALID, COUNT);
        else passed++;
        RD = 1'b0;
        tick();
        total++;
        if (UNDERFLOW !== 1'b0)
            $display("FAIL underflow_pulse got unf=%b exp 0", UNDERFLOW);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        fill_plain(16'h0001);
        WR = 1'b1; RD = 1'b1; DIN = 16'hBEEF;
        tick();
        total++;
        if (OVERFLOW !== 1'b0 || COUNT !== 6'd32 || FULL !== 1'b1 || DOUT !== 16'h0001)
            $display("FAIL full_wr_rd got ovf=%b count=%0d full=%b dout=%h exp 0/32/1/0001",
                     OVERFLOW, COUNT, FULL, DOUT);
        else passed++;
        WR = 1'b0;
        for (int k = 2; k <= 33; k++) begin
            exp = (k == 33) ? 16'hBEEF : 16'(k);
            tick();
            total++;
            if (DOUT !== exp || DOUT_VALID !== 1'b1)
                $display("FAIL b2b_read_%0d got dout=%h valid=%b exp %h/1", k, DOUT, DOUT_VALID, exp);
            else passed++;
        end
        WR = 1'b1; DIN = 16'h1234;
        tick();
        total++;
        if (UNDERFLOW !== 1'b1 || COUNT !== 6'd1 || DOUT_VALID !== 1'b0 || DOUT !== 16'hBEEF ||
            EMPTY !== 1'b0)
            $display("FAIL empty_wr_rd got unf=%b count=%0d valid=%b dout=%h empty=%b exp 1/1/0/beef/0",
                     UNDERFLOW, COUNT, DOUT_VALID, DOUT, EMPTY);
        else passed++;
        WR = 1'b0;
        tick();
        total++;
        if (DOUT !== 16'h1234 || EMPTY !== 1'b1)
            $display("FAIL empty_wr_rd_read got dout=%h empty=%b exp 1234/1", DOUT, EMPTY);
        else passed++;
        RD = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        int errs;
        errs = 0;
        for (int i = 0; i < 3; i++) begin
            WR = 1'b1; DIN = 16'h0100 + 16'(i);
            tick();
        end
        RD = 1'b1;
        for (int i = 3; i < 51; i++) begin
            DIN = 16'h0100 + 16'(i);
            tick();
            if (DOUT !== 16'h0100 + 16'(i - 3) || COUNT !== 6'd3 || DOUT_VALID !== 1'b1) begin
                errs++;
                $display("FAIL wrap_%0d got dout=%h count=%0d exp %h/3", i, DOUT, COUNT,
                         16'h0100 + 16'(i - 3));
            end
        end
        total++;
        if (errs == 0) passed++;
        WR = 1'b0;
        for (int i = 48; i < 51; i++) begin
            tick();
            total++;
            if (DOUT !== 16'h0100 + 16'(i))
                $display("FAIL wrap_tail_%0d got dout=%h exp %h", i, DOUT, 16'h0100 + 16'(i));
            else passed++;
        end
        RD = 1'b0;
        tick();
        total++;
        if (EMPTY !== 1'b1 || COUNT !== 6'd0)
            $display("FAIL wrap_empty got empty=%b count=%0d exp 1/0", EMPTY, COUNT);
        else passed++;
    endtask

    task automatic test_fwft();
        f_wr = 1'b1; f_din = 16'hA5A5;
        tick();
        total++;
        if (f_dout !== 16'hA5A5 || f_valid !== 1'b1 || f_empty !== 1'b0)
            $display("FAIL fwft_first got dout=%h valid=%b empty=%b exp a5a5/1/0", f_dout, f_valid, f_empty);
        else passed++;
        f_wr = 1'b0;
        tick();
        total++;
        if (f_dout !== 16'hA5A5 || f_valid !== 1'b1)
            $display("FAIL fwft_hold got dout=%h valid=%b exp a5a5/1", f_dout, f_valid);
        else passed++;
        f_wr = 1'b1; f_din = 16'h5A5A;
        tick();
        f_wr = 1'b0; f_rd = 1'b1;
        tick();
        total++;
        if (f_dout !== 16'h5A5A || f_valid !== 1'b1 || f_count !== 6'd1)
            $display("FAIL fwft_advance got dout=%h valid=%b count=%0d exp 5a5a/1/1", f_dout, f_valid, f_count);
        else passed++;
        tick();
        total++;
        if (f_empty !== 1'b1 || f_valid !== 1'b0)
            $display("FAIL fwft_empty got empty=%b valid=%b exp 1/0", f_empty, f_valid);
        else passed++;
        f_rd = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) begin
            WR = 1'b1; DIN = 16'h0300 + 16'(i);
            tick();
        end
        WR = 1'b0;
        total++;
        if (COUNT !== 6'd10)
            $display("FAIL pre_reset_count got %0d exp 10", COUNT);
        else passed++;
        @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        total++;
        if (COUNT !== 6'd0 || {EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, DOUT_VALID} !== 5'b10100 ||
            DOUT !== 16'h0000)
            $display("FAIL async_reset got count=%0d flags=%b dout=%h exp 0/10100/0000", COUNT,
                     {EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, DOUT_VALID}, DOUT);
        else passed++;
        @(posedge CLK);
        #3 RST = 1'b0;
        WR = 1'b1; DIN = 16'h7777;
        tick();
        total++;
        if (COUNT !== 6'd1 || EMPTY !== 1'b0)
            $display("FAIL post_reset_write got count=%0d empty=%b exp 1/0", COUNT, EMPTY);
        else passed++;
        WR = 1'b0; RD = 1'b1;
        tick();
        total++;
        if (DOUT !== 16'h7777 || DOUT_VALID !== 1'b1 || EMPTY !== 1'b1)
            $display("FAIL post_reset_read got dout=%h valid=%b empty=%b exp 7777/1/1", DOUT, DOUT_VALID, EMPTY);
        else passed++;
        RD = 1'b0;
        tick();
    endtask

    initial begin
        RST = 1'b1; WR = 1'b0; RD = 1'b0; DIN = '0;
        f_wr = 1'b0; f_rd = 1'b0; f_din = '0;
        #2;
        test_reset();
        tick();
        tick();
        RST = 1'b0;
        tick();
        test_fill();
        test_drain();
        test_back_to_back();
        test_wrap();
        test_fwft();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
